// File: rtl/bus_arbiter.sv
// Two-port (instruction/data) arbiter onto a single unified memory bus.
// One access in flight at a time; contention is resolved by alternating grants.
module bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [ADDR_WIDTH-1:0]   i_inst_addr,
    input  logic                    i_inst_re,
    output logic [DATA_WIDTH-1:0]   o_inst_inst,
    output logic                    o_inst_busy,
    input  logic [ADDR_WIDTH-1:0]   i_data_addr,
    input  logic                    i_data_re,
    input  logic                    i_data_we,
    input  logic [DATA_WIDTH/8-1:0] i_data_be,
    input  logic [DATA_WIDTH-1:0]   i_data_wdata,
    output logic [DATA_WIDTH-1:0]   o_data_rdata,
    output logic                    o_data_busy,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_re,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    input  logic                    i_mem_ready
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_e;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_e;

    state_e                  state_q, state_d;
    grant_e                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_re_q, mem_re_d;
    logic                    mem_we_q, mem_we_d;
    logic [BE_WIDTH-1:0]     mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic inst_pend;
    logic data_pend;

    assign inst_pend = i_inst_re;
    assign data_pend = i_data_re | i_data_we;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        inst_d       = inst_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            IDLE: begin
                // Under contention the port that lost last time wins.
                if (inst_pend && (!data_pend || last_grant_q == GRANT_DATA)) begin
                    state_d      = BUSY_I;
                    last_grant_d = GRANT_INST;
                    mem_addr_d   = i_inst_addr;
                    mem_re_d     = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '1;
                    mem_wdata_d  = '0;
                end else if (data_pend) begin
                    state_d      = BUSY_D;
                    last_grant_d = GRANT_DATA;
                    mem_addr_d   = i_data_addr;
                    // A combined read+write request is issued as a plain write.
                    mem_re_d     = i_data_re & ~i_data_we;
                    mem_we_d     = i_data_we;
                    mem_be_d     = i_data_be;
                    mem_wdata_d  = i_data_wdata;
                end
            end
            BUSY_I: begin
                if (i_mem_ready) begin
                    state_d  = DONE_I;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    inst_d   = i_mem_rdata;
                end
            end
            BUSY_D: begin
                if (i_mem_ready) begin
                    state_d  = DONE_D;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = i_mem_rdata;
                    end
                end
            end
            DONE_I, DONE_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_INST;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            inst_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_q       <= inst_d;
            rdata_q      <= rdata_d;
        end
    end

    assign o_mem_addr   = mem_addr_q;
    assign o_mem_re     = mem_re_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_be     = mem_be_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_inst_inst  = inst_q;
    assign o_data_rdata = rdata_q;

    // Busy drops only in the single completion cycle of the matching port.
    assign o_inst_busy = inst_pend & (state_q != DONE_I);
    assign o_data_busy = data_pend & (state_q != DONE_D);

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of all data ports; byte-enable width SHALL be DATA_WIDTH/8.
REQ-003 Ports SHALL be, one per line, name direction width meaning:
  i_clock  in  1  clock, rising edge
  i_reset  in  1  synchronous reset, active high
  i_inst_addr  in  ADDR_WIDTH  instruction fetch address
  i_inst_re  in  1  instruction read request
  o_inst_inst  out  DATA_WIDTH  fetched instruction
  o_inst_busy  out  1  instruction request not yet completed
  i_data_addr  in  ADDR_WIDTH  data address
  i_data_re  in  1  data read request
  i_data_we  in  1  data write request
  i_data_be  in  DATA_WIDTH/8  data byte enables
  i_data_wdata  in  DATA_WIDTH  write data
  o_data_rdata  out  DATA_WIDTH  read data
  o_data_busy  out  1  data request not yet completed
  o_mem_addr  out  ADDR_WIDTH  unified memory address
  o_mem_re  out  1  memory read strobe
  o_mem_we  out  1  memory write strobe
  o_mem_be  out  DATA_WIDTH/8  memory byte enables
  o_mem_wdata  out  DATA_WIDTH  memory write data
  i_mem_rdata  in  DATA_WIDTH  memory read data, valid when i_mem_ready=1
  i_mem_ready  in  1  memory completes current access this cycle
REQ-004 The block SHALL use one clock, i_clock; i_reset SHALL be synchronous and active-high.

Function
REQ-005 FSM states SHALL be IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-006 Pending requests in IDLE: inst = i_inst_re; data = i_data_re | i_data_we.
REQ-007 IDLE, only one pending -> grant it (BUSY_I or BUSY_D) next edge; none pending -> stay IDLE.
REQ-008 IDLE, both pending -> grant the port not granted last (last_grant register); last_grant updates on every grant.
REQ-009 On grant, o_mem_addr/o_mem_be/o_mem_wdata SHALL be registered from the granted port; o_mem_re/o_mem_we SHALL be registered from its re/we; inst grant SHALL drive o_mem_we=0, o_mem_be=all ones.
REQ-010 Data port with i_data_we=1 and i_data_re=1 SHALL be issued as a write only (o_mem_re=0).
REQ-011 Registered memory outputs SHALL hold constant throughout BUSY_x regardless of core-side input changes.
REQ-012 BUSY_x with i_mem_ready=0 -> stay; i_mem_ready=1 -> DONE_x next edge, o_mem_re/o_mem_we cleared on that same edge.
REQ-013 On the BUSY_I->DONE_I edge o_inst_inst SHALL capture i_mem_rdata; on BUSY_D->DONE_D for a read, o_data_rdata SHALL capture i_mem_rdata; a write SHALL leave o_data_rdata unchanged.
REQ-014 o_inst_inst/o_data_rdata SHALL hold their value until the next capture.
REQ-015 DONE_x SHALL last exactly one cycle, then IDLE; no grant issued from DONE_x.
REQ-016 o_inst_busy = i_inst_re & (state != DONE_I), combinational; o_data_busy = (i_data_re | i_data_we) & (state != DONE_D).
REQ-017 Minimum latency: request in IDLE at cycle 0, i_mem_ready=1 in cycle 1 -> busy low in cycle 2 with valid data.
REQ-018 Request withdrawn during BUSY_x SHALL NOT abort the memory access; it completes, DONE_x still occurs, and the result is discarded by the core.
REQ-019 i_mem_ready outside BUSY_x SHALL be ignored.

Reset
REQ-020 On i_reset=1 at a rising edge: state=IDLE, last_grant=INST, o_mem_re=0, o_mem_we=0, o_mem_addr=0, o_mem_be=0, o_mem_wdata=0, o_inst_inst=0, o_data_rdata=0.
REQ-021 Reset during BUSY_x SHALL abandon the access; strobes low from the next cycle, no DONE_x issued.

Verification
REQ-022 Inst read 0x100, mem ready after 3 wait cycles, rdata 0x00000013 -> o_mem_re=1 for 4 cycles, o_inst_busy low one cycle later with o_inst_inst=0x00000013.
REQ-023 Simultaneous inst 0x200 and data read 0x8000 from reset -> data granted first (last_grant=INST), inst granted after DONE_D; next simultaneous pair -> data first again (last grant was INST).
REQ-024 Data write 0x8004, be=4'b0011, wdata=0xDEADBEEF, re=1 also -> o_mem_we=1, o_mem_re=0, fields exact; o_data_rdata unchanged.
REQ-025 Inst address changed 0x300->0x304 mid-BUSY_I -> o_mem_addr stays 0x300 until completion.
REQ-026 i_reset asserted in BUSY_D with i_mem_ready=0 -> next cycle all strobes 0, state IDLE, no busy-low pulse.
REQ-027 Back-to-back inst reads, i_mem_ready tied 1 -> one completion every 3 cycles (IDLE, BUSY_I, DONE_I).
